// File: rtl/mac_row4_seq.sv
// Sequencer for a 4-stage FP16 systolic MAC row. It preloads four weights,
// streams X beats into the row, and collects row results in an output FIFO.
// X issue is credit-limited so the FIFO always has room for every beat in flight.
module mac_row4_seq #(
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 8,
  parameter int OBUF_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data,
  output logic [3:0]        row_enW,
  output logic [DATA_W-1:0] row_W,
  output logic              row_enX,
  output logic [DATA_W-1:0] row_X,
  input  logic [DATA_W-1:0] row_Y_i,
  input  logic              row_finish_i,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data
);

  localparam int CW  = LEN_W + 1;           // job counters
  localparam int SW  = CW + 1;              // credit sum
  localparam int AW  = $clog2(OBUF_DEPTH);  // FIFO pointer
  localparam int FCW = AW + 1;              // FIFO occupancy

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       len_q, len_d;
  logic [CW-1:0]       issued_q, issued_d;
  logic [CW-1:0]       received_q, received_d;
  logic [1:0]          w_idx_q, w_idx_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [3:0]          row_enW_q, row_enW_d;
  logic [DATA_W-1:0]   row_W_q, row_W_d;
  logic                row_enX_q, row_enX_d;
  logic [DATA_W-1:0]   row_X_q, row_X_d;

  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0]      count_q;
  logic [DATA_W-1:0]   mem [OBUF_DEPTH];

  logic [CW-1:0]       inflight;
  logic [SW-1:0]       credit_sum;
  logic                credit_ok;
  logic                w_hs, x_hs, push, pop, fifo_empty;

  // Beats the row still owes us, and whether one more beat still fits in the FIFO.
  assign inflight   = issued_q - received_q;
  assign credit_sum = SW'(inflight) + SW'(count_q);
  assign credit_ok  = credit_sum < SW'(OBUF_DEPTH);
  assign fifo_empty = (count_q == '0);

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign err_overflow = err_q;
  assign w_ready      = (state_q == LOAD_W);
  assign x_ready      = (state_q == STREAM) && (issued_q < len_q) && credit_ok;
  assign row_enW      = row_enW_q;
  assign row_W        = row_W_q;
  assign row_enX      = row_enX_q;
  assign row_X        = row_X_q;
  assign y_valid      = !fifo_empty;
  assign y_data       = mem[rd_ptr_q];

  assign w_hs = w_valid && w_ready;
  assign x_hs = x_valid && x_ready;
  assign push = row_finish_i && (inflight != '0);
  assign pop  = y_valid && y_ready;

  // Next-state logic for the sequencer FSM, counters and row-side drive registers.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;
    w_idx_d    = w_idx_q;
    err_d      = err_q;
    done_d     = 1'b0;
    row_enW_d  = 4'b0000;
    row_W_d    = row_W_q;
    row_enX_d  = 1'b0;
    row_X_d    = row_X_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD_W;
          len_d      = {1'b0, len_i};
          issued_d   = '0;
          received_d = '0;
          w_idx_d    = '0;
          err_d      = 1'b0;
        end
      end
      LOAD_W: begin
        if (w_hs) begin
          row_enW_d = 4'b0001 << w_idx_q;
          row_W_d   = w_data;
          w_idx_d   = w_idx_q + 2'd1;
          if (w_idx_q == 2'd3) begin
            state_d = (len_q != '0) ? STREAM : DRAIN;
          end
        end
      end
      STREAM: begin
        if (x_hs) begin
          row_enX_d = 1'b1;
          row_X_d   = x_data;
          issued_d  = issued_q + CW'(1);
          if (issued_q + CW'(1) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((received_q == issued_q) && fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Result capture runs in every state; a finish with nothing owed is dropped.
    if (push) begin
      received_d = received_q + CW'(1);
    end
    if (row_finish_i && (inflight == '0)) begin
      err_d = 1'b1;
    end
  end

  // Sequencer and row-drive registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      w_idx_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      row_enW_q  <= 4'b0000;
      row_W_q    <= '0;
      row_enX_q  <= 1'b0;
      row_X_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      w_idx_q    <= w_idx_d;
      err_q      <= err_d;
      done_q     <= done_d;
      row_enW_q  <= row_enW_d;
      row_W_q    <= row_W_d;
      row_enX_q  <= row_enX_d;
      row_X_q    <= row_X_d;
    end
  end

  // Output FIFO pointers and occupancy; push and pop may coincide at any level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + FCW'(1);
      else if (!push && pop) count_q <= count_q - FCW'(1);
    end
  end

  // FIFO storage written on every accepted row result.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the cleared count makes stale entries unobservable.
    if (push) begin
      mem[wr_ptr_q] <= row_Y_i;
    end
  end

endmodule

// File: tb/tb_mac_row4_seq.sv
// Directed bench for mac_row4_seq with a behavioural 6-cycle row model.
module tb_mac_row4_seq;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              busy, done, err_overflow;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [DATA_W-1:0] w_data = '0;
  logic              x_valid, x_ready;
  logic [DATA_W-1:0] x_data;
  logic [3:0]        row_enW;
  logic [DATA_W-1:0] row_W, row_X, row_Y_i, y_data;
  logic              row_enX, row_finish_i, y_valid;
  logic              y_ready = 1'b0;

  // Stimulus controls
  logic              x_en = 1'b0;
  logic              x_inc = 1'b0;
  int                x_base = 0;
  int                x_limit = 0;
  logic              spur_fin = 1'b0;
  logic [DATA_W-1:0] spur_y = '0;

  // Monitors
  int                hs_total = 0;
  int                done_total = 0;
  int                fin_total = 0;
  int                xr_total = 0;
  logic [DATA_W-1:0] yq [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_row4_seq #(.DATA_W(DATA_W), .LEN_W(LEN_W), .OBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_i(len_i),
    .busy(busy), .done(done), .err_overflow(err_overflow),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .row_enW(row_enW), .row_W(row_W), .row_enX(row_enX), .row_X(row_X),
    .row_Y_i(row_Y_i), .row_finish_i(row_finish_i),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data)
  );

  // X source: beat i of a job carries 0x3C00 + i when x_inc is set, else 1.0.
  assign x_valid = x_en && ((hs_total - x_base) < x_limit);
  assign x_data  = 16'h3C00 + (x_inc ? 16'(hs_total - x_base) : 16'h0000);

  // Row model: all weights are 1.0, so Y = 4*X, i.e. FP16 exponent + 2.
  logic [5:0]        pv = '0;
  logic [DATA_W-1:0] pd [6];
  always @(posedge clk) begin
    pv    <= {pv[4:0], row_enX};
    pd[0] <= row_X + 16'h0800;
    for (int i = 1; i < 6; i++) pd[i] <= pd[i-1];
    if (pv[5]) fin_total <= fin_total + 1;
  end
  assign row_finish_i = pv[5] | spur_fin;
  assign row_Y_i      = spur_fin ? spur_y : pd[5];

  always @(posedge clk) begin
    if (x_valid && x_ready) hs_total <= hs_total + 1;
    if (done) done_total <= done_total + 1;
    if (x_ready) xr_total <= xr_total + 1;
    if (y_valid && y_ready) yq.push_back(y_data);
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(dut.push && !dut.pop && dut.count_q == DEPTH))
        else $error("FAIL fifo_overflow: push into full FIFO");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_job(input int len);
    @(negedge clk);
    start = 1'b1;
    len_i = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents four weights back-to-back and checks the one-hot preload pulses.
  task automatic load_w(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                        input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3);
    logic [DATA_W-1:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    w_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w_data = w[k];
      @(negedge clk);
      check($sformatf("row_enW_%0d", k), 32'(row_enW), 32'(4'b0001 << k));
      check($sformatf("row_W_%0d", k), 32'(row_W), 32'(w[k]));
    end
    w_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_total;
    n = 0;
    while (done_total == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_total != d0), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err_overflow), 0);
    check({tag, "_w_ready"}, 32'(w_ready), 0);
    check({tag, "_x_ready"}, 32'(x_ready), 0);
    check({tag, "_row_enW"}, 32'(row_enW), 0);
    check({tag, "_row_W"}, 32'(row_W), 0);
    check({tag, "_row_enX"}, 32'(row_enX), 0);
    check({tag, "_row_X"}, 32'(row_X), 0);
    check({tag, "_y_valid"}, 32'(y_valid), 0);
  endtask

  initial begin
    int h0, d0, y0, f0, xr0;

    // Power-on reset
    cyc(3);
    check_idle_outputs("por");
    rst_n = 1'b1;
    cyc(1);

    // Weight load with len = 0
    xr0 = xr_total;
    start_job(0);
    check("lw_busy", 32'(busy), 1);
    check("lw_w_ready", 32'(w_ready), 1);
    load_w(16'h3C00, 16'h4000, 16'h4200, 16'h4400);
    @(negedge clk);
    check("lw_done", 32'(done), 1);
    check("lw_busy_at_done", 32'(busy), 0);
    check("lw_row_enW_idle", 32'(row_enW), 0);
    @(negedge clk);
    check("lw_done_one_cycle", 32'(done), 0);
    check("lw_x_ready_never", 32'(xr_total - xr0), 0);

    // Basic stream: four beats of 1.0 give 4.0 each
    y_ready = 1'b1; x_en = 1'b1; x_inc = 1'b0; x_limit = 1000;
    x_base = hs_total; y0 = yq.size(); d0 = done_total;
    start_job(4);
    load_w(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    wait_done("basic", 200);
    cyc(3);
    check("basic_hs", 32'(hs_total - x_base), 4);
    check("basic_ny", 32'(yq.size() - y0), 4);
    for (int i = 0; i < 4; i++) check($sformatf("basic_y%0d", i), 32'(yq[y0+i]), 32'h4400);
    check("basic_done_once", 32'(done_total - d0), 1);
    check("basic_err", 32'(err_overflow), 0);

    // Backpressure: only DEPTH beats issue while results are stuck in the FIFO
    y_ready = 1'b0; x_inc = 1'b1; x_limit = 1000;
    x_base = hs_total; y0 = yq.size(); d0 = done_total; f0 = fin_total;
    start_job(20);
    load_w(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    cyc(60);
    check("bp_hs_stalled", 32'(hs_total - x_base), 8);
    check("bp_x_ready", 32'(x_ready), 0);
    check("bp_fin", 32'(fin_total - f0), 8);
    check("bp_y_valid", 32'(y_valid), 1);
    check("bp_err", 32'(err_overflow), 0);
    check("bp_busy", 32'(busy), 1);
    y_ready = 1'b1;
    wait_done("bp", 400);
    cyc(3);
    check("bp_hs_total", 32'(hs_total - x_base), 20);
    check("bp_ny", 32'(yq.size() - y0), 20);
    for (int i = 0; i < 20; i++)
      check($sformatf("bp_y%0d", i), 32'(yq[y0+i]), 32'(16'h4400 + 16'(i)));
    check("bp_done_once", 32'(done_total - d0), 1);
    check("bp_err_end", 32'(err_overflow), 0);

    // Spurious finish in IDLE
    @(negedge clk);
    spur_fin = 1'b1; spur_y = 16'h1234;
    @(negedge clk);
    spur_fin = 1'b0;
    check("spur_err", 32'(err_overflow), 1);
    check("spur_y_valid", 32'(y_valid), 0);
    cyc(2);
    check("spur_err_sticky", 32'(err_overflow), 1);
    check("spur_y_valid_later", 32'(y_valid), 0);
    start_job(0);
    check("spur_err_cleared", 32'(err_overflow), 0);
    load_w(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    wait_done("spur", 20);

    // Start while busy is ignored
    x_inc = 1'b1; x_limit = 0;
    x_base = hs_total; y0 = yq.size(); d0 = done_total;
    start_job(3);
    load_w(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    @(negedge clk);
    start = 1'b1; len_i = 8'd9;
    @(negedge clk);
    start = 1'b0;
    check("sb_busy", 32'(busy), 1);
    x_limit = 1000;
    wait_done("sb", 200);
    cyc(10);
    check("sb_hs", 32'(hs_total - x_base), 3);
    check("sb_ny", 32'(yq.size() - y0), 3);
    check("sb_done_once", 32'(done_total - d0), 1);
    check("sb_idle", 32'(busy), 0);

    // Reset mid-STREAM with three results held in the FIFO
    y_ready = 1'b0; x_inc = 1'b1; x_limit = 3;
    x_base = hs_total; d0 = done_total;
    start_job(10);
    load_w(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    cyc(20);
    check("rst_pre_hs", 32'(hs_total - x_base), 3);
    check("rst_pre_y_valid", 32'(y_valid), 1);
    check("rst_pre_busy", 32'(busy), 1);
    x_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    cyc(5);
    check("rst_no_done", 32'(done_total - d0), 0);
    check("rst_y_valid_after", 32'(y_valid), 0);
    check("rst_busy_after", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_row4_seq.md
Name: mac_row4_seq

Overview:
- Sequencer for the 4-stage FP16 systolic MAC row; drives the row's control and data side.
- Accepts a job (start + length), preloads four weights through a valid/ready stream, then streams X beats into the row.
- Captures each row result (Y on finish) into an output FIFO and presents results on a valid/ready port.
- Credit-limits X issue so row results are never dropped under output backpressure (the row cannot stall).

Parameters:
DATA_W, 16, FP16 word width
LEN_W, 8, width of job length field (max 255 X beats)
OBUF_DEPTH, 8, output FIFO depth (power of 2, ≥2); also the credit limit

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
start  in  1  job start pulse; accepted only in IDLE
len_i  in  LEN_W  number of X beats; sampled at start
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at job completion
err_overflow  out  1  sticky: row finish arrived with no outstanding beat
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat ready
w_data  in  DATA_W  weight; beats 0..3 map to W0..W3
x_valid  in  1  X beat valid
x_ready  out  1  X beat ready
x_data  in  DATA_W  X value
row_enW  out  4  one-hot weight preload enable to row
row_W  out  DATA_W  weight data, common to all four row weight inputs
row_enX  out  1  X stream enable to row
row_X  out  DATA_W  X data to row
row_Y_i  in  DATA_W  row result
row_finish_i  in  1  row result valid
y_valid  out  1  result valid (FIFO not empty)
y_ready  in  1  result consumer ready
y_data  out  DATA_W  FIFO head (first-word fall-through)

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; busy, done, err_overflow, w_ready, x_ready, row_enX, y_valid = 0; row_enW = 4'b0; row_W, row_X = 0; counters and FIFO cleared. Applies mid-job with no completion pulse.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE:
  - start=1 → LOAD_W; latch len_i; clear issued/received counters, weight index, and err_overflow.
  - start is ignored in every other state.
- LOAD_W:
  - w_ready=1.
  - On each w handshake (beat k): next cycle row_enW = 1<<k and row_W = w_data; otherwise row_enW = 0.
  - After beat 3 is accepted: → STREAM if len≠0, else → DRAIN.
- STREAM:
  - Definitions: inflight = issued − received; credit_ok = (inflight + fifo_count) < OBUF_DEPTH.
  - x_ready = (issued < len) && credit_ok; combinational from registered state only.
  - On each x handshake: next cycle row_enX=1, row_X=x_data; issued++. Otherwise row_enX=0 and row_X holds its value.
  - When issued == len after a handshake → DRAIN.
- DRAIN:
  - Condition: received == issued && fifo empty → assert done for 1 cycle, go to IDLE.
  - busy drops in the same cycle done is high.
- Result capture, in any state:
  - If row_finish_i=1 and inflight>0: push row_Y_i into the FIFO and increment received.
  - If row_finish_i=1 and inflight==0: drop the result and set err_overflow (sticky until reset or next accepted start).
  - The credit rule guarantees the FIFO never overflows. An overflow would be a design bug; the bench asserts it never occurs.
- FIFO:
  - Simultaneous push and pop are allowed at any occupancy, including full and empty.
  - No bypass: a push to an empty FIFO sets y_valid on the next cycle.
  - Results leave in arrival order.
- Widths: all counters are LEN_W+1 bits; no wrap within a job.
- Row latency is not assumed. Completion is counted by finish pulses only, one finish per issued X beat.

Test Plan:
1. Reset check: assert rst_n=0 mid-STREAM with FIFO holding 3 entries → next cycle all outputs 0, y_valid=0, state IDLE, no done pulse.
2. Weight load: start, len=0; w_data 0x3C00, 0x4000, 0x4200, 0x4400 with w_valid held high → row_enW = 0001, 0010, 0100, 1000 on 4 consecutive cycles with the matching row_W; done pulse follows, x_ready never high.
3. Basic stream: behavioural row model (latency 6, Y = ΣX·Wk) with weights all 0x3C00; start len=4; X = 0x3C00 ×4; y_ready=1 → four y beats of 0x4400 (4.0), done after the last pop, err_overflow=0.
4. Backpressure: y_ready=0, len=20 → exactly 8 X handshakes, then x_ready stays 0 and the FIFO is full. Release y_ready → remaining 12 are issued; 20 results arrive in order; done once.
5. Spurious finish: in IDLE, pulse row_finish_i with row_Y_i=0x1234 → err_overflow=1 and y_valid stays 0. Next start → err_overflow=0.
6. Start during busy: in STREAM, assert start with len_i=9 → ignored; the job completes with the original len and issued count.
